// File: rtl/wrsw_traffic_gen_pkg.sv
// Shared constants, generator state type and header-word builder for the traffic generator
// and its receive checker.
package wrsw_traffic_gen_pkg;

  localparam logic [7:0]  c_w0_type   = 8'h50;
  localparam logic [15:0] c_w1        = 16'hCAFE;
  localparam logic [15:0] c_w2        = 16'hBABE;
  localparam logic [7:0]  c_w3_type   = 8'h02;
  localparam logic [15:0] c_w4        = 16'h0304;
  localparam logic [15:0] c_w5        = 16'h0506;
  localparam logic [15:0] c_w6        = 16'h88F7;
  localparam logic [15:0] c_lfsr_seed = 16'hACE1;
  localparam int unsigned c_hdr_words = 9;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPayload,
    StGap,
    StDone
  } gen_state_e;

  // Header word idx (0..8); idx 8 carries the payload length.
  function automatic logic [15:0] hdr_word(input logic [3:0]  idx,
                                           input logic [7:0]  dst,
                                           input logic [7:0]  src,
                                           input logic [15:0] seq,
                                           input logic [11:0] len);
    logic [15:0] w;
    case (idx)
      4'd0:    w = {dst, c_w0_type};
      4'd1:    w = c_w1;
      4'd2:    w = c_w2;
      4'd3:    w = {src, c_w3_type};
      4'd4:    w = c_w4;
      4'd5:    w = c_w5;
      4'd6:    w = c_w6;
      4'd7:    w = seq;
      default: w = {4'h0, len};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wrsw_traffic_chk.sv
// Receive-side checker: compares incoming frames with the generator layout and keeps
// received-frame and bad-frame counters.
module wrsw_traffic_chk
  import wrsw_traffic_gen_pkg::*;
#(
  parameter int unsigned g_num_ports = 16,
  parameter int unsigned g_port_id   = 0,
  parameter int unsigned g_cnt_width = 16
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_n_i,
  input  logic                   mirror_i,
  input  logic [7:0]             dst_port_i,
  input  logic [15:0]            snk_data_i,
  input  logic                   snk_valid_i,
  input  logic                   snk_sof_i,
  input  logic                   snk_eof_i,
  output logic                   snk_dreq_o,
  output logic [g_cnt_width-1:0] rx_count_o,
  output logic [g_cnt_width-1:0] err_count_o
);

  localparam logic [7:0]             MyId   = 8'(g_port_id);
  localparam logic [7:0]             PeerId = 8'(g_num_ports - 1 - g_port_id);
  localparam logic [g_cnt_width-1:0] CntOne = 1;

  logic                   dreq_q;
  logic                   open_q, open_d;
  logic                   bad_q, bad_d;
  logic [12:0]            widx_q, widx_d;
  logic [11:0]            len_q, len_d;
  logic [g_cnt_width-1:0] rx_q, rx_d, err_q, err_d;

  logic        xfer, word_bad, frame_bad;
  logic [12:0] idx;
  logic [11:0] len_now;
  logic [15:0] exp_seq;
  logic [7:0]  exp_src;

  assign xfer    = snk_valid_i && dreq_q;
  assign idx     = snk_sof_i ? 13'd0 : widx_q;
  assign exp_seq = 16'(rx_q);
  assign exp_src = mirror_i ? PeerId : dst_port_i;
  assign len_now = (idx == 13'd8) ? snk_data_i[11:0] : len_q;

  always_comb begin
    if (idx == 13'd8) begin
      word_bad = (snk_data_i[15:12] != 4'h0);
    end else if (idx < 13'(c_hdr_words)) begin
      word_bad = (snk_data_i != hdr_word(idx[3:0], MyId, exp_src, exp_seq, 12'h0));
    end else begin
      word_bad = (snk_data_i != exp_seq + 16'(idx - 13'(c_hdr_words)) + 16'd1);
    end
  end

  always_comb begin
    open_d    = open_q;
    bad_d     = bad_q;
    widx_d    = widx_q;
    len_d     = len_q;
    rx_d      = rx_q;
    err_d     = err_q;
    frame_bad = 1'b0;
    if (xfer && (snk_sof_i || open_q)) begin
      // A sof on an open frame abandons it: one error, then restart with this word.
      if (snk_sof_i && open_q && !(&err_d)) err_d = err_d + CntOne;
      open_d = 1'b1;
      bad_d  = snk_sof_i ? word_bad : (bad_q || word_bad);
      widx_d = (&widx_q) ? widx_q : idx + 13'd1;
      if (idx == 13'd8) len_d = snk_data_i[11:0];
      if (snk_eof_i) begin
        open_d    = 1'b0;
        frame_bad = bad_d || (idx + 13'd1 != 13'(c_hdr_words) + {1'b0, len_now});
        if (!(&rx_q)) rx_d = rx_q + CntOne;
        if (frame_bad && !(&err_d)) err_d = err_d + CntOne;
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dreq_q <= 1'b0;
      open_q <= 1'b0;
      bad_q  <= 1'b0;
      widx_q <= '0;
      len_q  <= '0;
      rx_q   <= '0;
      err_q  <= '0;
    end else begin
      dreq_q <= 1'b1;
      open_q <= open_d;
      bad_q  <= bad_d;
      widx_q <= widx_d;
      len_q  <= len_d;
      rx_q   <= rx_d;
      err_q  <= err_d;
    end
  end

  assign snk_dreq_o  = dreq_q;
  assign rx_count_o  = rx_q;
  assign err_count_o = err_q;

endmodule

// File: rtl/wrsw_traffic_gen.sv
// Switch-port traffic generator: emits numbered test frames with growing length and
// pseudo-random gaps, and checks frames arriving on the receive stream.
module wrsw_traffic_gen
  import wrsw_traffic_gen_pkg::*;
#(
  parameter int unsigned g_num_ports = 16,
  parameter int unsigned g_port_id   = 0,
  parameter int unsigned g_cnt_width = 16
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic                   mirror_i,
  input  logic [7:0]             dst_port_i,
  input  logic [g_cnt_width-1:0] n_frames_i,
  input  logic [11:0]            len_min_i,
  input  logic [11:0]            len_max_i,
  input  logic                   gap_en_i,
  input  logic [15:0]            gap_min_i,
  input  logic [15:0]            gap_max_i,
  output logic [15:0]            src_data_o,
  output logic                   src_valid_o,
  output logic                   src_sof_o,
  output logic                   src_eof_o,
  input  logic                   src_dreq_i,
  input  logic [15:0]            snk_data_i,
  input  logic                   snk_valid_i,
  input  logic                   snk_sof_i,
  input  logic                   snk_eof_i,
  output logic                   snk_dreq_o,
  output logic [g_cnt_width-1:0] tx_count_o,
  output logic [g_cnt_width-1:0] rx_count_o,
  output logic [g_cnt_width-1:0] err_count_o,
  output logic                   done_o
);

  localparam logic [7:0]             MyId    = 8'(g_port_id);
  localparam logic [7:0]             PeerId  = 8'(g_num_ports - 1 - g_port_id);
  localparam logic [11:0]            HdrLast = 12'(c_hdr_words - 1);
  localparam logic [g_cnt_width-1:0] CntOne  = 1;

  gen_state_e             state_q, state_d, post_state;
  logic [11:0]            widx_q, widx_d, len_q, len_d, next_len;
  logic [15:0]            seq_q, seq_d, lfsr_q, lfsr_d, gap_q, gap_d, gap_val;
  logic [16:0]            gap_sum;
  logic [g_cnt_width-1:0] tx_count_q, tx_count_d, run_cnt_q, run_cnt_d, run_next;
  logic [7:0]             dst;
  logic                   limit_hit, in_frame, eof_word, xfer, eof_xfer;

  assign dst       = mirror_i ? PeerId : dst_port_i;
  assign limit_hit = (n_frames_i != '0) && (run_cnt_q >= n_frames_i);
  assign in_frame  = (state_q == StHdr || state_q == StPayload) && !limit_hit;
  assign eof_word  = (state_q == StHdr) ? (widx_q == HdrLast && len_q == '0)
                                        : (widx_q == len_q - 12'd1);
  assign xfer      = in_frame && src_dreq_i;
  assign eof_xfer  = xfer && eof_word;

  // Gap for the frame just finished uses the LFSR value before this frame's step.
  assign gap_sum  = {1'b0, gap_min_i} + {9'h0, lfsr_q[7:0]};
  assign gap_val  = (gap_sum > {1'b0, gap_max_i}) ? gap_max_i : gap_sum[15:0];
  assign next_len = (len_max_i < len_min_i || len_q >= len_max_i) ? len_min_i : len_q + 12'd1;
  assign run_next = (&run_cnt_q) ? run_cnt_q : run_cnt_q + CntOne;

  always_comb begin
    if (n_frames_i != '0 && run_next >= n_frames_i) begin
      post_state = StDone;
    end else if (!enable_i) begin
      post_state = StIdle;
    end else if (gap_en_i && gap_val != '0) begin
      post_state = StGap;
    end else begin
      post_state = StHdr;
    end
  end

  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    seq_d      = seq_q;
    len_d      = len_q;
    lfsr_d     = lfsr_q;
    gap_d      = gap_q;
    tx_count_d = tx_count_q;
    run_cnt_d  = run_cnt_q;
    unique case (state_q)
      StIdle: begin
        run_cnt_d = '0;
        if (enable_i) begin
          state_d = StHdr;
          widx_d  = '0;
          seq_d   = '0;
          len_d   = len_min_i;
        end
      end
      StHdr: begin
        if (xfer && widx_q == HdrLast && len_q != '0) begin
          state_d = StPayload;
          widx_d  = '0;
        end else if (xfer && widx_q != HdrLast) begin
          widx_d = widx_q + 12'd1;
        end
      end
      StPayload: if (xfer && !eof_word) widx_d = widx_q + 12'd1;
      StGap: begin
        if (!enable_i) state_d = StIdle;
        else if (gap_q == '0) state_d = StHdr;
        else gap_d = gap_q - 16'd1;
      end
      StDone: if (!enable_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (eof_xfer) begin
      state_d    = post_state;
      widx_d     = '0;
      seq_d      = seq_q + 16'd1;
      len_d      = next_len;
      lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      gap_d      = gap_val - 16'd1;
      tx_count_d = (&tx_count_q) ? tx_count_q : tx_count_q + CntOne;
      run_cnt_d  = run_next;
    end

    if (limit_hit && (state_q == StHdr || state_q == StPayload || state_q == StGap)) begin
      state_d = StDone;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      widx_q     <= '0;
      seq_q      <= '0;
      len_q      <= '0;
      lfsr_q     <= c_lfsr_seed;
      gap_q      <= '0;
      tx_count_q <= '0;
      run_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      seq_q      <= seq_d;
      len_q      <= len_d;
      lfsr_q     <= lfsr_d;
      gap_q      <= gap_d;
      tx_count_q <= tx_count_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  always_comb begin
    src_valid_o = in_frame;
    src_sof_o   = in_frame && state_q == StHdr && widx_q == '0;
    src_eof_o   = in_frame && eof_word;
    src_data_o  = '0;
    if (in_frame) begin
      src_data_o = (state_q == StHdr) ? hdr_word(widx_q[3:0], dst, MyId, seq_q, len_q)
                                      : seq_q + 16'(widx_q) + 16'd1;
    end
  end

  assign tx_count_o = tx_count_q;
  assign done_o     = (state_q == StDone);

  wrsw_traffic_chk #(
    .g_num_ports (g_num_ports),
    .g_port_id   (g_port_id),
    .g_cnt_width (g_cnt_width)
  ) u_chk (
    .clk_sys_i   (clk_sys_i),
    .rst_n_i     (rst_n_i),
    .mirror_i    (mirror_i),
    .dst_port_i  (dst_port_i),
    .snk_data_i  (snk_data_i),
    .snk_valid_i (snk_valid_i),
    .snk_sof_i   (snk_sof_i),
    .snk_eof_i   (snk_eof_i),
    .snk_dreq_o  (snk_dreq_o),
    .rx_count_o  (rx_count_o),
    .err_count_o (err_count_o)
  );

endmodule
